// File: rtl/gpr_read_port_if.sv
// Read-side bus of the GPR block: request handshake with two addresses, and a
// valid/ready response channel that carries the two read-data words.
interface gpr_read_port_if #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] raddr1;
   logic [ADDR_W-1:0] raddr2;
   logic              resp_valid;
   logic              resp_ready;
   logic [WIDTH-1:0]  rdata1;
   logic [WIDTH-1:0]  rdata2;

   modport master (
      output req_valid, raddr1, raddr2, resp_ready,
      input  req_ready, resp_valid, rdata1, rdata2
   );

   modport slave (
      input  req_valid, raddr1, raddr2, resp_ready,
      output req_ready, resp_valid, rdata1, rdata2
   );
endinterface

// File: rtl/gpr_read_port.sv
// NPC general-purpose register file: one plain write port, one handshaked dual-read
// port with a single-entry registered response. Define GPR_READ_BYPASS_EN to forward
// a same-cycle write into the read response.
module gpr_read_port #(
   parameter int               WIDTH  = 32,
   parameter int               NREG   = 32,
   parameter logic [WIDTH-1:0] INIT   = '0,
   localparam int              ADDR_W = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wen,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   gpr_read_port_if.slave    rd
);

   logic [WIDTH-1:0] regs [NREG];
   logic [WIDTH-1:0] lookup1;
   logic [WIDTH-1:0] lookup2;
   logic [WIDTH-1:0] rdata1_q;
   logic [WIDTH-1:0] rdata2_q;
   logic             resp_valid_q;
   logic             accept;

   assign rd.req_ready  = !resp_valid_q || rd.resp_ready;
   assign accept        = rd.req_valid && rd.req_ready;
   assign rd.resp_valid = resp_valid_q;
   assign rd.rdata1     = rdata1_q;
   assign rd.rdata2     = rdata2_q;

   // Entry 0 is never written; its reads are forced to zero in the lookup instead.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= INIT;
         end
      end else if (wen && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   always_comb begin
      lookup1 = regs[rd.raddr1];
      lookup2 = regs[rd.raddr2];
`ifdef GPR_READ_BYPASS_EN
      if (wen && (waddr == rd.raddr1)) begin
         lookup1 = wdata;
      end
      if (wen && (waddr == rd.raddr2)) begin
         lookup2 = wdata;
      end
`endif
      // Applied last so a bypassed write to address 0 still reads as zero.
      if (rd.raddr1 == '0) begin
         lookup1 = '0;
      end
      if (rd.raddr2 == '0) begin
         lookup2 = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         resp_valid_q <= 1'b0;
         rdata1_q     <= INIT;
         rdata2_q     <= INIT;
      end else if (accept) begin
         resp_valid_q <= 1'b1;
         rdata1_q     <= lookup1;
         rdata2_q     <= lookup2;
      end else if (rd.resp_ready) begin
         resp_valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gpr_read_port.sv
// Directed testbench for gpr_read_port: expected responses are queued at issue time
// and a negedge monitor compares them whenever a response handshake occurs.
module tb_gpr_read_port;

   localparam int          WIDTH   = 32;
   localparam int          NREG    = 32;
   localparam int          ADDR_W  = 5;
   localparam logic [31:0] TB_INIT = 32'h1357_9BDF;
`ifdef GPR_READ_BYPASS_EN
   localparam logic [31:0] SAME_CYCLE_EXP = 32'h0000_0022;
`else
   localparam logic [31:0] SAME_CYCLE_EXP = 32'h0000_0011;
`endif

   logic              clk;
   logic              reset;
   logic              wen;
   logic [ADDR_W-1:0] waddr;
   logic [WIDTH-1:0]  wdata;

   int          compareCount;
   int          failCount;
   logic        modelValid;
   logic [63:0] expQueue [$];

   gpr_read_port_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) rd ();

   gpr_read_port #(
      .WIDTH (WIDTH),
      .NREG  (NREG),
      .INIT  (TB_INIT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .wen   (wen),
      .waddr (waddr),
      .wdata (wdata),
      .rd    (rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compareCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one cycle of inputs starting just after a rising edge and returns just after the next.
   task automatic applyStimulus(
      input logic              we,
      input logic [ADDR_W-1:0] wa,
      input logic [WIDTH-1:0]  wd,
      input logic              rv,
      input logic [ADDR_W-1:0] a1,
      input logic [ADDR_W-1:0] a2,
      input logic              rr,
      input logic [WIDTH-1:0]  e1,
      input logic [WIDTH-1:0]  e2
   );
      logic expReady;
      logic acc;
      wen           = we;
      waddr         = wa;
      wdata         = wd;
      rd.req_valid  = rv;
      rd.raddr1     = a1;
      rd.raddr2     = a2;
      rd.resp_ready = rr;
      expReady = !modelValid || rr;
      acc      = rv && expReady;
      @(negedge clk);
      checkOutput("req_ready", {63'd0, rd.req_ready}, {63'd0, expReady});
      @(posedge clk);
      #1;
      if (acc) expQueue.push_back({e1, e2});
      modelValid = acc ? 1'b1 : (rr ? 1'b0 : modelValid);
      wen          = 1'b0;
      rd.req_valid = 1'b0;
   endtask

   // Scoreboard monitor: a response is consumed when valid and ready are both high.
   always @(negedge clk) begin
      logic [63:0] exp;
      if (reset && rd.resp_valid && rd.resp_ready) begin
         compareCount++;
         if (expQueue.size() == 0) begin
            failCount++;
            $display("[TB] FAIL sb_unexpected: got 0x%0h_%0h, expected no response at %0t",
                     rd.rdata1, rd.rdata2, $time);
         end else begin
            exp = expQueue.pop_front();
            if ({rd.rdata1, rd.rdata2} !== exp) begin
               failCount++;
               $display("[TB] FAIL sb_resp: got 0x%0h_%0h, expected 0x%0h_%0h at %0t",
                        rd.rdata1, rd.rdata2, exp[63:32], exp[31:0], $time);
            end
         end
      end
   end

   initial begin
      #200000;
      failCount++;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      compareCount  = 0;
      failCount     = 0;
      modelValid    = 1'b0;
      reset         = 1'b0;
      wen           = 1'b0;
      waddr         = '0;
      wdata         = '0;
      rd.req_valid  = 1'b0;
      rd.raddr1     = '0;
      rd.raddr2     = '0;
      rd.resp_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_resp_valid", {63'd0, rd.resp_valid}, 64'd0);
      checkOutput("rst_req_ready", {63'd0, rd.req_ready}, 64'd1);
      checkOutput("rst_rdata1", {32'd0, rd.rdata1}, {32'd0, TB_INIT});
      checkOutput("rst_rdata2", {32'd0, rd.rdata2}, {32'd0, TB_INIT});
      reset = 1'b1;
      $display("[TB] reset released");

      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0, 1'b1, TB_INIT, 32'h0);
      applyStimulus(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0, 1'b1, 32'hDEAD_BEEF, 32'h0);
      checkOutput("wr_rd_valid", {63'd0, rd.resp_valid}, 64'd1);
      checkOutput("wr_rd_rdata1", {32'd0, rd.rdata1}, 64'hDEAD_BEEF);

      $display("[TB] same-cycle write/read");
      applyStimulus(1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0);
      applyStimulus(1'b1, 5'd7, 32'h22, 1'b1, 5'd7, 5'd7, 1'b1, SAME_CYCLE_EXP, SAME_CYCLE_EXP);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd3, 1'b1, 32'h22, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0);

      $display("[TB] stall hold");
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd7, 1'b0, 32'hDEAD_BEEF, 32'h22);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 5'd3, 32'hCAFE_F00D, 1'b1, 5'd4, 5'd3, 1'b0, 32'h0, 32'h0);
         checkOutput("stall_valid", {63'd0, rd.resp_valid}, 64'd1);
         checkOutput("stall_rdata1", {32'd0, rd.rdata1}, 64'hDEAD_BEEF);
         checkOutput("stall_rdata2", {32'd0, rd.rdata2}, 64'h22);
      end
      applyStimulus(1'b1, 5'd1, 32'h1111_0001, 1'b1, 5'd4, 5'd3, 1'b1, TB_INIT, 32'hCAFE_F00D);

      $display("[TB] throughput");
      applyStimulus(1'b1, 5'd2, 32'h2222_0002, 1'b1, 5'd1, 5'd0, 1'b1, 32'h1111_0001, 32'h0);
      checkOutput("tp_valid1", {63'd0, rd.resp_valid}, 64'd1);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 5'd0, 1'b1, 32'h2222_0002, 32'h0);
      checkOutput("tp_valid2", {63'd0, rd.resp_valid}, 64'd1);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0, 1'b1, 32'hCAFE_F00D, 32'h0);
      checkOutput("tp_valid3", {63'd0, rd.resp_valid}, 64'd1);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd0, 1'b1, TB_INIT, 32'h0);
      checkOutput("tp_valid4", {63'd0, rd.resp_valid}, 64'd1);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0);
      checkOutput("tp_drain", {63'd0, rd.resp_valid}, 64'd0);

      $display("[TB] x0 write");
      applyStimulus(1'b1, 5'd0, 32'h0000_FFFF, 1'b0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0);
      applyStimulus(1'b1, 5'd0, 32'h0000_FFFF, 1'b1, 5'd0, 5'd5, 1'b1, 32'h0, TB_INIT);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0);

      $display("[TB] async reset mid-stall");
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd2, 1'b0, 32'h1111_0001, 32'h2222_0002);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
      checkOutput("pre_rst_valid", {63'd0, rd.resp_valid}, 64'd1);
      #2;
      reset = 1'b0;
      wen   = 1'b1;
      waddr = 5'd5;
      wdata = 32'hDEAD_0005;
      #1;
      checkOutput("async_rst_valid", {63'd0, rd.resp_valid}, 64'd0);
      checkOutput("async_rst_rdata1", {32'd0, rd.rdata1}, {32'd0, TB_INIT});
      expQueue.delete();
      @(posedge clk);
      #1;
      wen        = 1'b0;
      reset      = 1'b1;
      modelValid = 1'b0;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd1, 1'b1, TB_INIT, TB_INIT);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0);

      repeat (2) @(negedge clk);
      checkOutput("sb_drained", 64'(expQueue.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
